// File: rtl/phase_frame_sequencer_if.sv
// Bank-write and command channels between the UART command decoder and the
// phase frame sequencer.
interface phase_frame_sequencer_if #(
  parameter int unsigned FRAME_WIDTH  = 2,
  parameter int unsigned CH_WIDTH     = 8,
  parameter int unsigned OFFSET_WIDTH = 11,
  parameter int unsigned HOLD_WIDTH   = 16
) ();
  logic                    wr_valid;
  logic                    wr_ready;
  logic [FRAME_WIDTH-1:0]  wr_frame;
  logic [CH_WIDTH-1:0]     wr_channel;
  logic [OFFSET_WIDTH-1:0] wr_offset;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [FRAME_WIDTH-1:0]  cmd_frame;
  logic [FRAME_WIDTH-1:0]  cmd_last;
  logic [HOLD_WIDTH-1:0]   cmd_hold;

  modport master (
    output wr_valid, wr_frame, wr_channel, wr_offset,
    output cmd_valid, cmd_op, cmd_frame, cmd_last, cmd_hold,
    input  wr_ready, cmd_ready
  );

  modport slave (
    input  wr_valid, wr_frame, wr_channel, wr_offset,
    input  cmd_valid, cmd_op, cmd_frame, cmd_last, cmd_hold,
    output wr_ready, cmd_ready
  );
endinterface

// File: rtl/phase_frame_sequencer.sv
// Stores banks of per-channel phase offsets and applies them to the generator
// array on carrier-period boundaries, optionally animating through a bank range.
module phase_frame_sequencer #(
  parameter int unsigned OUTPUTS      = 64,
  parameter int unsigned OFFSET_WIDTH = 11,
  parameter int unsigned FRAMES       = 4,
  parameter int unsigned FRAME_WIDTH  = 2,
  parameter int unsigned CH_WIDTH     = 8,
  parameter int unsigned HOLD_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  phase_frame_sequencer_if.slave           bus,
  input  logic                             carrier_sync,
  output logic [OFFSET_WIDTH*OUTPUTS-1:0]  offsets,
  output logic                             reload,
  output logic                             busy,
  output logic                             playing,
  output logic [FRAME_WIDTH-1:0]           cur_frame
);

  localparam int unsigned BUS_W    = OFFSET_WIDTH * OUTPUTS;
  localparam int unsigned CH_IDX_W = $clog2(OUTPUTS);
  localparam int unsigned CH_CMP_W = CH_WIDTH + 1;

  localparam logic [1:0] OP_COMMIT = 2'b00;
  localparam logic [1:0] OP_PLAY   = 2'b01;
  localparam logic [1:0] OP_STOP   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_APPLY,
    ST_RELOAD,
    ST_PLAY_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [FRAME_WIDTH-1:0]  target_q, target_d;
  logic [FRAME_WIDTH-1:0]  first_q, first_d;
  logic [FRAME_WIDTH-1:0]  last_q, last_d;
  logic [HOLD_WIDTH-1:0]   hold_q, hold_d;
  logic [HOLD_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    playing_q, playing_d;
  logic [FRAME_WIDTH-1:0]  cur_frame_q, cur_frame_d;
  logic [BUS_W-1:0]        offsets_q, offsets_d;
  logic                    reload_q, reload_d;
  logic                    busy_q, busy_d;
  logic                    cmd_ready_q, cmd_ready_d;

  logic [OFFSET_WIDTH-1:0] store_q [FRAMES][OUTPUTS];
  logic [OFFSET_WIDTH-1:0] store_d [FRAMES][OUTPUTS];

  logic                    cmd_fire_c;
  logic                    wr_hit_c;

  assign cmd_fire_c = bus.cmd_valid && cmd_ready_q;
  // Writes to channels beyond the array are accepted but dropped.
  assign wr_hit_c   = bus.wr_valid &&
                      ({1'b0, bus.wr_channel} < CH_CMP_W'(OUTPUTS));

  assign bus.wr_ready = 1'b1;
  assign bus.cmd_ready = cmd_ready_q;
  assign offsets   = offsets_q;
  assign reload    = reload_q;
  assign busy      = busy_q;
  assign playing   = playing_q;
  assign cur_frame = cur_frame_q;

  // Bank store next state.
  always_comb begin
    store_d = store_q;
    if (wr_hit_c) begin
      store_d[bus.wr_frame][bus.wr_channel[CH_IDX_W-1:0]] = bus.wr_offset;
    end
  end

  // Sequencer next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    first_d     = first_q;
    last_d      = last_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    playing_d   = playing_q;
    cur_frame_d = cur_frame_q;
    offsets_d   = offsets_q;
    reload_d    = 1'b1;

    case (state_q)
      ST_IDLE, ST_PLAY_WAIT: begin
        // An accepted command takes priority over a terminal playback sync.
        if (cmd_fire_c && bus.cmd_op == OP_COMMIT) begin
          target_d  = bus.cmd_frame;
          playing_d = 1'b0;
          state_d   = ST_WAIT_SYNC;
        end else if (cmd_fire_c && bus.cmd_op == OP_PLAY) begin
          first_d   = bus.cmd_frame;
          last_d    = bus.cmd_last;
          hold_d    = (bus.cmd_hold == '0) ? HOLD_WIDTH'(1) : bus.cmd_hold;
          target_d  = bus.cmd_frame;
          playing_d = 1'b1;
          state_d   = ST_WAIT_SYNC;
        end else if (cmd_fire_c && bus.cmd_op == OP_STOP) begin
          playing_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (state_q == ST_PLAY_WAIT && carrier_sync) begin
          cnt_d = cnt_q - HOLD_WIDTH'(1);
          if (cnt_q == HOLD_WIDTH'(1)) begin
            target_d = (target_q == last_q) ? first_q
                                            : target_q + FRAME_WIDTH'(1);
            state_d  = ST_APPLY;
          end
        end
      end
      ST_WAIT_SYNC: begin
        if (carrier_sync) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        for (int unsigned i = 0; i < OUTPUTS; i++) begin
          offsets_d[i*OFFSET_WIDTH +: OFFSET_WIDTH] = store_q[target_q][i];
        end
        cur_frame_d = target_q;
        reload_d    = 1'b0;
        state_d     = ST_RELOAD;
      end
      ST_RELOAD: begin
        if (playing_q) begin
          cnt_d   = hold_q;
          state_d = ST_PLAY_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_PLAY_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      first_q     <= '0;
      last_q      <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      playing_q   <= 1'b0;
      cur_frame_q <= '0;
      offsets_q   <= '0;
      reload_q    <= 1'b1;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      for (int unsigned f = 0; f < FRAMES; f++) begin
        for (int unsigned c = 0; c < OUTPUTS; c++) begin
          store_q[f][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      first_q     <= first_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      playing_q   <= playing_d;
      cur_frame_q <= cur_frame_d;
      offsets_q   <= offsets_d;
      reload_q    <= reload_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      store_q     <= store_d;
    end
  end

endmodule

// File: tb/tb_phase_frame_sequencer.sv
// Directed and randomized bench for phase_frame_sequencer against an
// event-level model of bank storage and carrier-synchronous playback.
module tb_phase_frame_sequencer;

  localparam int unsigned OUTPUTS = 64;
  localparam int unsigned OW      = 11;
  localparam int unsigned FRAMES  = 4;
  localparam int unsigned FW      = 2;
  localparam int unsigned CHW     = 8;
  localparam int unsigned HW      = 16;
  localparam int unsigned BUSW    = OW * OUTPUTS;

  localparam logic [1:0] OP_COMMIT = 2'b00;
  localparam logic [1:0] OP_PLAY   = 2'b01;
  localparam logic [1:0] OP_STOP   = 2'b10;

  logic            clk = 1'b0;
  logic            rst;
  logic            carrier_sync;
  logic [BUSW-1:0] offsets;
  logic            reload;
  logic            busy;
  logic            playing;
  logic [FW-1:0]   cur_frame;

  phase_frame_sequencer_if #(
    .FRAME_WIDTH(FW), .CH_WIDTH(CHW), .OFFSET_WIDTH(OW), .HOLD_WIDTH(HW)
  ) bus ();

  phase_frame_sequencer #(
    .OUTPUTS(OUTPUTS), .OFFSET_WIDTH(OW), .FRAMES(FRAMES),
    .FRAME_WIDTH(FW), .CH_WIDTH(CHW), .HOLD_WIDTH(HW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .carrier_sync (carrier_sync),
    .offsets      (offsets),
    .reload       (reload),
    .busy         (busy),
    .playing      (playing),
    .cur_frame    (cur_frame)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: bank contents, what is on the generator bus, and the playback plan.
  logic [OW-1:0]   mem [FRAMES][OUTPUTS];
  logic [BUSW-1:0] exp_off;
  int              exp_cur;
  int              m_first, m_last, m_hold, m_target, m_cnt;
  int              m_playing, m_pending;

  task automatic check(input string tag, input logic [BUSW-1:0] obs,
                       input logic [BUSW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_s(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUSW-1:0] frame_bus(input int f);
    logic [BUSW-1:0] r;
    for (int i = 0; i < OUTPUTS; i++) r[i*OW +: OW] = mem[f][i];
    return r;
  endfunction

  function automatic int next_frame(input int t);
    return (t == m_last) ? m_first : (t + 1) % FRAMES;
  endfunction

  task automatic model_reset();
    for (int f = 0; f < FRAMES; f++)
      for (int c = 0; c < OUTPUTS; c++) mem[f][c] = '0;
    exp_off   = '0;
    exp_cur   = 0;
    m_playing = 0;
    m_pending = 0;
    m_cnt     = 0;
    m_target  = 0;
  endtask

  task automatic wr(input int f, input int ch, input logic [OW-1:0] val);
    @(negedge clk);
    bus.wr_valid   = 1'b1;
    bus.wr_frame   = FW'(f);
    bus.wr_channel = CHW'(ch);
    bus.wr_offset  = val;
    check_s("wr_ready", 32'(bus.wr_ready), 32'd1);
    if (ch < OUTPUTS) mem[f][ch] = val;
  endtask

  task automatic wr_end();
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input int f, input int l, input int h);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_frame = FW'(f);
    bus.cmd_last  = FW'(l);
    bus.cmd_hold  = HW'(h);
    check_s("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    if (op == OP_COMMIT) begin
      m_target = f; m_playing = 0; m_pending = 1;
    end else if (op == OP_PLAY) begin
      m_first = f; m_last = l; m_hold = (h == 0) ? 1 : h;
      m_target = f; m_playing = 1; m_pending = 1; m_cnt = 0;
    end else if (op == OP_STOP) begin
      m_playing = 0; m_pending = 0;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // One carrier pulse after gap idle cycles; checks the reload window T+1..T+3.
  task automatic sync_step(input int gap);
    logic rl;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    carrier_sync = 1'b1;
    rl = 1'b0;
    if (m_pending != 0) begin
      rl = 1'b1;
      m_pending = 0;
      m_cnt = 0;
    end else if (m_playing != 0) begin
      m_cnt++;
      if (m_cnt >= m_hold) begin
        m_cnt = 0;
        m_target = next_frame(m_target);
        rl = 1'b1;
      end
    end
    if (rl) begin
      exp_off = frame_bus(m_target);
      exp_cur = m_target;
    end
    @(negedge clk);
    carrier_sync = 1'b0;
    check_s("reload_t1", 32'(reload), 32'd1);
    if (rl) check_s("cmd_ready_apply", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check_s("reload_t2", 32'(reload), rl ? 32'd0 : 32'd1);
    check("offsets", offsets, exp_off);
    check_s("cur_frame", 32'(cur_frame), 32'(exp_cur));
    @(negedge clk);
    check_s("reload_t3", 32'(reload), 32'd1);
    check_s("busy", 32'(busy), 32'(m_playing != 0));
    check_s("playing", 32'(playing), 32'(m_playing));
  endtask

  task automatic check_reset_state(input string tag);
    check_s({tag, "_reload"}, 32'(reload), 32'd1);
    check({tag, "_offsets"}, offsets, '0);
    check_s({tag, "_busy"}, 32'(busy), 32'd0);
    check_s({tag, "_playing"}, 32'(playing), 32'd0);
    check_s({tag, "_cur_frame"}, 32'(cur_frame), 32'd0);
  endtask

  initial begin
    int c;
    rst = 1'b0;
    carrier_sync = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_frame = '0; bus.wr_channel = '0; bus.wr_offset = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_frame = '0; bus.cmd_last = '0;
    bus.cmd_hold = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    check_s("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Single write then commit: only channel 5 of bank 1 carries a value.
    wr(1, 5, 11'h123);
    wr_end();
    check("write_no_bus_change", offsets, exp_off);
    cmd(OP_COMMIT, 1, 0, 0);
    sync_step(10);
    check_s("ch5_value", 32'(offsets[5*OW +: OW]), 32'h123);

    // Out-of-range channel is discarded.
    wr(0, 70, 11'($urandom));
    wr_end();
    cmd(OP_COMMIT, 0, 0, 0);
    sync_step(3);

    // Randomized bank fill, then commit every bank.
    for (int n = 0; n < 150; n++)
      wr($urandom_range(0, FRAMES - 1), $urandom_range(0, 79), 11'($urandom));
    wr_end();
    check("bulk_write_no_bus_change", offsets, exp_off);
    for (int f = 0; f < FRAMES; f++) begin
      cmd(OP_COMMIT, f, 0, 0);
      sync_step($urandom_range(0, 4));
    end

    // Wrapping playback 2,3,0 with three periods per frame.
    cmd(OP_PLAY, 2, 0, 3);
    for (int n = 0; n < 19; n++) sync_step(16);

    // Zero hold behaves as one; writes reach the bus only on the next apply.
    cmd(OP_PLAY, 1, 1, 0);
    for (int n = 0; n < 3; n++) sync_step($urandom_range(0, 3));
    for (int n = 0; n < 8; n++) wr(1, $urandom_range(0, OUTPUTS - 1), 11'($urandom));
    wr_end();
    check("play_write_no_bus_change", offsets, exp_off);
    for (int n = 0; n < 2; n++) sync_step(1);

    // Stop keeps the last frame on the bus and ends pulses.
    cmd(OP_STOP, 0, 0, 0);
    for (int n = 0; n < 3; n++) sync_step(2);

    // Randomized playback ranges.
    for (int k = 0; k < 5; k++) begin
      cmd(OP_PLAY, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int n = 0; n < 9; n++) sync_step($urandom_range(0, 3));
    end

    // Commit preempts an active playback.
    cmd(OP_COMMIT, 2, 0, 0);
    sync_step(1);

    // Command arriving with a terminal sync wins and the step is dropped.
    cmd(OP_PLAY, 0, 3, 1);
    sync_step(0);
    @(negedge clk);
    carrier_sync = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_COMMIT; bus.cmd_frame = 2'd3;
    m_target = 3; m_playing = 0; m_pending = 1;
    @(negedge clk);
    carrier_sync = 1'b0;
    bus.cmd_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      check_s("collide_no_reload", 32'(reload), 32'd1);
      @(negedge clk);
    end
    check("collide_offsets", offsets, exp_off);
    sync_step(2);

    // Reset while waiting for a sync.
    cmd(OP_COMMIT, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("rst_wait_sync");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Reset during the reload cycle.
    wr(2, 9, 11'h5a5);
    wr_end();
    cmd(OP_COMMIT, 2, 0, 0);
    @(negedge clk);
    carrier_sync = 1'b1;
    @(negedge clk);
    carrier_sync = 1'b0;
    @(negedge clk);
    check_s("reload_before_rst", 32'(reload), 32'd0);
    rst = 1'b0;
    #1;
    check_reset_state("rst_reload");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Normal commit after reset.
    c = $urandom_range(0, OUTPUTS - 1);
    wr(3, c, 11'h7ff);
    wr(3, 63, 11'h2b1);
    wr_end();
    cmd(OP_COMMIT, 3, 0, 0);
    sync_step(4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
